// File: rtl/player_death_if.sv
// Bundle between the player death controller and the hazard, motion and render logic.
interface player_death_if #(
    parameter int unsigned N_HAZARD = 4
);
    logic                frame_tick;
    logic [N_HAZARD-1:0] death_in;
    logic [N_HAZARD-1:0] hazard_en;
    logic [9:0]          char_Y;
    logic                start;
    logic                freeze;
    logic                dying;
    logic [9:0]          anim_dy;
    logic                respawn;
    logic [9:0]          spawn_x;
    logic [9:0]          spawn_y;
    logic [2:0]          lives;
    logic                game_over;
    logic                blink;

    // Game/testbench side: drives frame timing, hazard flags and position.
    modport master (
        output frame_tick, death_in, hazard_en, char_Y, start,
        input  freeze, dying, anim_dy, respawn, spawn_x, spawn_y, lives, game_over, blink
    );

    // Controller side.
    modport slave (
        input  frame_tick, death_in, hazard_en, char_Y, start,
        output freeze, dying, anim_dy, respawn, spawn_x, spawn_y, lives, game_over, blink
    );
endinterface

// File: rtl/player_death_ctrl.sv
// Player death controller: merges hazard and pit deaths, runs the death animation,
// counts lives and requests respawn / game over.
// Optional feature macro INVULN_EN: adds a post-respawn invulnerability window with
// sprite blinking (pit death still kills during it).
module player_death_ctrl #(
    parameter int unsigned N_HAZARD      = 4,
    parameter int unsigned LIVES_INIT    = 3,
    parameter int unsigned DEATH_FRAMES  = 48,
    parameter logic [9:0]  PIT_Y         = 10'd220,
    parameter logic [9:0]  SPAWN_X       = 10'd20,
    parameter logic [9:0]  SPAWN_Y       = 10'd180,
    parameter int unsigned INVULN_FRAMES = 90
) (
    input logic           sys_clk,
    input logic           RST_N,
    player_death_if.slave bus
);
    localparam int unsigned MAX_FRAMES = (DEATH_FRAMES > INVULN_FRAMES) ? DEATH_FRAMES : INVULN_FRAMES;
    localparam int unsigned CNT_W      = $clog2(MAX_FRAMES + 1);
    localparam logic [CNT_W-1:0] DEATH_LAST  = CNT_W'(DEATH_FRAMES);
    localparam logic [CNT_W-1:0] INVULN_LAST = CNT_W'(INVULN_FRAMES);
    localparam logic [2:0]       LIVES_RST   = 3'(LIVES_INIT);

    typedef enum logic [2:0] {
        ST_ALIVE,
        ST_DYING,
        ST_RESPAWN,
        ST_GAME_OVER,
        ST_INVULN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0]       lives_q, lives_d;
    logic             freeze_q, freeze_d;
    logic             dying_q, dying_d;
    logic [9:0]       anim_q, anim_d;
    logic             respawn_q, respawn_d;
    logic             game_over_q, game_over_d;
    logic             blink_q, blink_d;
    logic [N_HAZARD-1:0] hz_hit;
    logic             pit;
    logic             hit;
    logic [9:0]       cnt_ext;

    assign hz_hit  = bus.death_in & bus.hazard_en;
    assign pit     = (bus.char_Y >= PIT_Y);
    assign hit     = (|hz_hit) | pit;
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state, counter, lives and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lives_d = lives_q;
        blink_d = 1'b0;
        case (state_q)
            ST_ALIVE: begin
                if (hit) begin
                    state_d = ST_DYING;
                    cnt_d   = '0;
                end
            end
            ST_DYING: begin
                if (bus.frame_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DEATH_LAST) begin
                        cnt_d = '0;
                        if (lives_q <= 3'd1) begin
                            lives_d = 3'd0;
                            state_d = ST_GAME_OVER;
                        end else begin
                            lives_d = lives_q - 3'd1;
                            state_d = ST_RESPAWN;
                        end
                    end
                end
            end
            ST_RESPAWN: begin
                cnt_d = '0;
`ifdef INVULN_EN
                state_d = ST_INVULN;
`else
                state_d = ST_ALIVE;
`endif
            end
            ST_GAME_OVER: begin
                if (bus.start) begin
                    lives_d = LIVES_RST;
                    state_d = ST_RESPAWN;
                end
            end
`ifdef INVULN_EN
            ST_INVULN: begin
                blink_d = blink_q;
                if (pit) begin
                    // Falling into the pit cannot be survived, even while protected.
                    state_d = ST_DYING;
                    cnt_d   = '0;
                    blink_d = 1'b0;
                end else if (bus.frame_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc[1:0] == 2'b00) begin
                        blink_d = ~blink_q;
                    end
                    if (cnt_inc == INVULN_LAST) begin
                        state_d = ST_ALIVE;
                        cnt_d   = '0;
                        blink_d = 1'b0;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_ALIVE;
                cnt_d   = '0;
            end
        endcase

        // Outputs follow the next state so they change together with it.
        freeze_d    = !((state_d == ST_ALIVE) || (state_d == ST_INVULN));
        dying_d     = (state_d == ST_DYING);
        respawn_d   = (state_d == ST_RESPAWN);
        game_over_d = (state_d == ST_GAME_OVER);
        cnt_ext     = 10'(cnt_d);
        // Hop up 2 px per frame for 16 frames, fall back down for 16, then rest.
        if (!dying_d || cnt_ext >= 10'd32) begin
            anim_d = '0;
        end else if (cnt_ext < 10'd16) begin
            anim_d = cnt_ext << 1;
        end else begin
            anim_d = 10'd64 - (cnt_ext << 1);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_ALIVE;
            cnt_q       <= '0;
            lives_q     <= LIVES_RST;
            freeze_q    <= 1'b0;
            dying_q     <= 1'b0;
            anim_q      <= '0;
            respawn_q   <= 1'b0;
            game_over_q <= 1'b0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lives_q     <= lives_d;
            freeze_q    <= freeze_d;
            dying_q     <= dying_d;
            anim_q      <= anim_d;
            respawn_q   <= respawn_d;
            game_over_q <= game_over_d;
            blink_q     <= blink_d;
        end
    end

    assign bus.freeze    = freeze_q;
    assign bus.dying     = dying_q;
    assign bus.anim_dy   = anim_q;
    assign bus.respawn   = respawn_q;
    assign bus.spawn_x   = SPAWN_X;
    assign bus.spawn_y   = SPAWN_Y;
    assign bus.lives     = lives_q;
    assign bus.game_over = game_over_q;
    assign bus.blink     = blink_q;
endmodule

// File: tb/tb_player_death_ctrl.sv
// Directed testbench for player_death_ctrl (default build, INVULN_EN undefined).
module tb_player_death_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    player_death_if #(.N_HAZARD(4)) bus ();

    player_death_ctrl dut (
        .sys_clk (clk),
        .RST_N   (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Absolute time bound on the whole run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: run still active, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        step(1);
        bus.frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    int pts  [9] = '{1, 8, 15, 16, 17, 24, 31, 32, 40};
    int exps [9] = '{2, 16, 30, 32, 30, 16, 2, 0, 0};

    initial begin
        int idx;
        rst_n          = 1'b0;
        bus.frame_tick = 1'b0;
        bus.death_in   = 4'b0000;
        bus.hazard_en  = 4'b1111;
        bus.char_Y     = 10'd100;
        bus.start      = 1'b0;
        step(2);

        // Reset values
        chk("rst_freeze", 32'(bus.freeze), 0);
        chk("rst_dying", 32'(bus.dying), 0);
        chk("rst_anim", 32'(bus.anim_dy), 0);
        chk("rst_respawn", 32'(bus.respawn), 0);
        chk("rst_lives", 32'(bus.lives), 3);
        chk("rst_game_over", 32'(bus.game_over), 0);
        chk("rst_blink", 32'(bus.blink), 0);
        chk("spawn_x", 32'(bus.spawn_x), 20);
        chk("spawn_y", 32'(bus.spawn_y), 180);
        rst_n = 1'b1;
        step(1);

        // Masked hazard and start while alive do nothing
        bus.death_in  = 4'b0010;
        bus.hazard_en = 4'b1101;
        bus.start     = 1'b1;
        step(3);
        chk("masked_dying", 32'(bus.dying), 0);
        chk("masked_freeze", 32'(bus.freeze), 0);
        chk("start_alive_respawn", 32'(bus.respawn), 0);
        chk("masked_lives", 32'(bus.lives), 3);
        bus.start = 1'b0;

        // Pit boundary: 219 is safe
        bus.death_in = 4'b0000;
        bus.char_Y   = 10'd219;
        step(2);
        chk("pit219_dying", 32'(bus.dying), 0);
        bus.char_Y = 10'd100;

        // Enabled hazard death, full sequence to respawn
        bus.hazard_en = 4'b1111;
        bus.death_in  = 4'b0010;
        step(1);
        bus.death_in = 4'b0000;
        chk("t1_dying", 32'(bus.dying), 1);
        chk("t1_freeze", 32'(bus.freeze), 1);
        chk("t1_anim0", 32'(bus.anim_dy), 0);
        ticks(47);
        chk("t1_dying47", 32'(bus.dying), 1);
        chk("t1_lives47", 32'(bus.lives), 3);
        tick();
        chk("t1_respawn", 32'(bus.respawn), 1);
        chk("t1_resp_freeze", 32'(bus.freeze), 1);
        chk("t1_resp_dying", 32'(bus.dying), 0);
        chk("t1_lives", 32'(bus.lives), 2);
        step(1);
        chk("t1_respawn_pulse", 32'(bus.respawn), 0);
        chk("t1_alive_freeze", 32'(bus.freeze), 0);

        // Pit death and animation profile
        bus.char_Y = 10'd220;
        step(1);
        bus.char_Y = 10'd100;
        chk("t3_dying", 32'(bus.dying), 1);
        chk("t3_anim0", 32'(bus.anim_dy), 0);
        idx = 0;
        for (int k = 1; k <= 47; k++) begin
            tick();
            if (idx < 9 && k == pts[idx]) begin
                chk($sformatf("t3_anim_tick%0d", k), 32'(bus.anim_dy), 32'(exps[idx]));
                idx++;
            end
        end
        tick();
        chk("t3_respawn", 32'(bus.respawn), 1);
        chk("t3_lives", 32'(bus.lives), 1);
        step(1);

        // Tick coincident with hit: not counted; last life leads to game over
        bus.death_in   = 4'b1000;
        bus.frame_tick = 1'b1;
        step(1);
        bus.death_in   = 4'b0000;
        bus.frame_tick = 1'b0;
        chk("t5_dying", 32'(bus.dying), 1);
        chk("t5_anim0", 32'(bus.anim_dy), 0);
        ticks(47);
        chk("t5_dying47", 32'(bus.dying), 1);
        tick();
        chk("t4_game_over", 32'(bus.game_over), 1);
        chk("t4_lives0", 32'(bus.lives), 0);
        chk("t4_freeze", 32'(bus.freeze), 1);
        chk("t4_no_respawn", 32'(bus.respawn), 0);

        // Game over is sticky against hits and ticks
        bus.death_in = 4'b1111;
        ticks(5);
        bus.death_in = 4'b0000;
        chk("t4_sticky", 32'(bus.game_over), 1);
        chk("t4_sticky_lives", 32'(bus.lives), 0);

        // Restart
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk("t4_restart_respawn", 32'(bus.respawn), 1);
        chk("t4_restart_lives", 32'(bus.lives), 3);
        chk("t4_restart_go", 32'(bus.game_over), 0);
        step(1);
        chk("t4_restart_alive", 32'(bus.freeze), 0);

        // Lose one life, then reset mid-sequence
        bus.death_in = 4'b0001;
        step(1);
        bus.death_in = 4'b0000;
        ticks(48);
        step(1);
        chk("t5_lives2", 32'(bus.lives), 2);
        bus.death_in = 4'b0100;
        step(1);
        bus.death_in = 4'b0000;
        ticks(20);
        chk("t5_anim20", 32'(bus.anim_dy), 24);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_dying", 32'(bus.dying), 0);
        chk("t5_rst_freeze", 32'(bus.freeze), 0);
        chk("t5_rst_anim", 32'(bus.anim_dy), 0);
        chk("t5_rst_lives", 32'(bus.lives), 3);
        step(1);
        rst_n = 1'b1;
        step(2);
        chk("t5_post_rst_dying", 32'(bus.dying), 0);
        chk("t5_blink", 32'(bus.blink), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
